// File: rtl/cover_pkg.sv
// Shared constants and helpers for the toggle cover collectors.
// Global sizing, index type, popcount and width helpers.
package cover_pkg;

  localparam int COVER_TOTAL = 8065;
  localparam int IDX_W       = 32;
  localparam int MAX_W       = 1024;

  typedef logic [IDX_W-1:0] cover_idx_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [10:0] popcount(
    input logic [MAX_W-1:0] v
  );
    logic [10:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + {10'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit encoder.
// Gives any-set flag, bit position and one-hot mask.
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter int WIDTH = 9,
  localparam int POS_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic             any,
  output logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    any    = |in_bits;
    onehot = in_bits & (~in_bits + WIDTH'(1));
    pos    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_bits[i]) pos = POS_W'(i);
    end
  end

endmodule

// File: rtl/gen_toggle_cover_collector.sv
// Sticky toggle cover collector: dedups first hits and
// streams their global indices lowest-first on valid/ready.
module gen_toggle_cover_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
  parameter int IDX_W       = 32,
  localparam int CNT_W      = $clog2(WIDTH + 1),
  localparam int POS_W      = clog2_min1(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_covered
);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_chk
    $error("cover group exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] hit_q, hit_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] new_w;
  logic [WIDTH-1:0] acc_mask;
  logic [WIDTH-1:0] low_oh;
  logic [POS_W-1:0] low_pos;
  logic             any_pend;

  cover_prio_enc #(.WIDTH(WIDTH)) u_prio (
    .in_bits (pend_q),
    .any     (any_pend),
    .pos     (low_pos),
    .onehot  (low_oh)
  );

  always_comb begin
    new_w    = valid & ~hit_q & {WIDTH{enable}};
    acc_mask = (any_pend && out_ready) ? low_oh : '0;
    hit_d    = hit_q | new_w;
    pend_d   = (pend_q | new_w) & ~acc_mask;
    cnt_d    = cnt_q + CNT_W'(popcount(MAX_W'(new_w)));
    if (reset || clear) begin
      hit_d  = '0;
      pend_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    hit_q  <= hit_d;
    pend_q <= pend_d;
    cnt_q  <= cnt_d;
  end

  assign out_valid   = any_pend;
  assign out_index   = IDX_W'(COVER_INDEX) + IDX_W'(low_pos);
  assign hit_count   = cnt_q;
  assign all_covered = (cnt_q == CNT_W'(WIDTH));

endmodule
